// File: rtl/prog_loader.sv
// Serial program loader: unpacks a framed byte stream into 16-bit instruction words,
// writes them from address 0 and releases the core only after a clean checksum.
module prog_loader #(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [0:15]       mem_wdata,
   output logic              core_run,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int RW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CHK, DONE, ERR} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [7:0]      hi_byte;
   logic [7:0]      lo_byte;
   logic [7:0]      acc;
   logic [RW-1:0]   remaining;
   logic [TW-1:0]   idle_cnt;
   logic            xfer;
   logic            is_sync;
   logic            timed;
   logic            timeout_hit;

   // Handshake: a byte moves when rx_valid & rx_ready are both high at a rising edge;
   // rx_ready is low only in reset and during the single WRITE cycle.
   always_comb begin
      rx_ready    = !rst && (state != WRITE);
      xfer        = rx_valid && rx_ready;
      is_sync     = xfer && (rx_data == SYNC_BYTE);
      timed       = (state == COUNT) || (state == HI) || (state == LO) || (state == CHK);
      timeout_hit = timed && !xfer && (idle_cnt == TW'(TIMEOUT - 1));
      state_nxt   = state;
      case (state)
         IDLE, DONE, ERR: if (is_sync) state_nxt = COUNT;
         COUNT:           if (xfer) state_nxt = HI;
         HI:              if (xfer) state_nxt = LO;
         LO:              if (xfer) state_nxt = WRITE;
         WRITE:           state_nxt = (remaining == RW'(1)) ? CHK : HI;
         CHK:             if (xfer) state_nxt = (rx_data == acc) ? DONE : ERR;
         default:         state_nxt = IDLE;
      endcase
      if (timeout_hit) state_nxt = ERR;

      mem_we    = (state == WRITE) && !rst;
      mem_addr  = addr;
      mem_wdata = {hi_byte, lo_byte};
      done      = (state == DONE);
      core_run  = (state == DONE);
      err       = (state == ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         addr         <= '0;
         hi_byte      <= '0;
         lo_byte      <= '0;
         acc          <= '0;
         remaining    <= '0;
         idle_cnt     <= '0;
         words_loaded <= '0;
      end else begin
         state    <= state_nxt;
         idle_cnt <= (timed && !xfer) ? idle_cnt + TW'(1) : '0;
         case (state)
            IDLE, DONE, ERR: begin
               if (is_sync) begin
                  addr         <= '0;
                  acc          <= '0;
                  words_loaded <= '0;
               end
            end
            COUNT: begin
               // A count of zero means a full memory image.
               if (xfer) remaining <= (rx_data == 8'd0) ? (RW'(1) << ADDR_W) : RW'(rx_data);
            end
            HI: begin
               if (xfer) begin
                  hi_byte <= rx_data;
                  acc     <= acc ^ rx_data;
               end
            end
            LO: begin
               if (xfer) begin
                  lo_byte <= rx_data;
                  acc     <= acc ^ rx_data;
               end
            end
            WRITE: begin
               addr         <= addr + ADDR_W'(1);
               words_loaded <= words_loaded + (ADDR_W + 1)'(1);
               remaining    <= remaining - RW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: random framed loads checked against a word-list model,
// with a write monitor draining an expected-write queue.
module tb_prog_loader;

   localparam int         ADDR_W  = 8;
   localparam int         TIMEOUT = 1000;
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         W       = ADDR_W + 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [0:15]       mem_wdata;
   logic              core_run;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   logic [W-1:0] exp_q[$];
   logic [15:0]  frame_words[$];
   int total = 0;
   int bad   = 0;

   prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_run(core_run),
      .done(done), .err(err), .words_loaded(words_loaded)
   );

   // clock / reset / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         total++;
         bad++;
         $display("FAIL rx_ready_wait: byte %h never accepted, expected acceptance within 20 cycles", b);
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic send_gap(input logic [7:0] b, input int max_gap);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(b);
   endtask

   task automatic fill_random(input int n);
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
   endtask

   // Reference: word i lands at address i mod depth; CHK is the XOR of every data byte.
   task automatic run_frame(input int n_field, input bit corrupt, input int max_gap, input bit chk_drop);
      int          cnt;
      logic [7:0]  chk;
      cnt = (n_field == 0) ? (1 << ADDR_W) : n_field;
      chk = 8'h00;
      for (int i = 0; i < cnt; i++) begin
         chk ^= frame_words[i][15:8] ^ frame_words[i][7:0];
         exp_q.push_back({ADDR_W'(i), frame_words[i]});
      end
      if (corrupt) chk ^= 8'h01;
      send_gap(SYNC, max_gap);
      if (chk_drop) begin
         @(negedge clk);
         rx_valid = 1'b0;
         check("core_run_drop_after_sync", {31'd0, core_run}, 32'd0);
      end
      send_gap(8'(n_field), max_gap);
      for (int i = 0; i < cnt; i++) begin
         send_gap(frame_words[i][15:8], max_gap);
         send_gap(frame_words[i][7:0], max_gap);
      end
      send_gap(chk, max_gap);
      @(negedge clk);
      rx_valid = 1'b0;
      check("core_run_latency", {31'd0, core_run}, {31'd0, !corrupt});
      idle(2);
      check("done", {31'd0, done}, {31'd0, !corrupt});
      check("err", {31'd0, err}, {31'd0, corrupt});
      check("core_run", {31'd0, core_run}, {31'd0, !corrupt});
      check("words_loaded", 32'(words_loaded), 32'(cnt));
      check("writes_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (mem_we) begin
         check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(e));
         end
      end
      if (done || err) check("done_err_exclusive", {31'd0, done & err}, 32'd0);
   end

   // stimulus
   initial begin
      @(negedge clk);
      check("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("reset_mem_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {mem_addr, mem_wdata, core_run, done, err}, 32'd0);
      check("reset_words", 32'(words_loaded), 32'd0);
      check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

      // good frame, back-to-back
      frame_words.delete();
      frame_words.push_back(16'h4005);
      frame_words.push_back(16'hF801);
      run_frame(2, 1'b0, 0, 1'b0);

      // bad checksum (BD)
      run_frame(2, 1'b1, 0, 1'b0);

      // garbage before sync from IDLE
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      run_frame(2, 1'b0, 0, 1'b0);

      // timeout after the first hi byte
      send_byte(SYNC);
      send_byte(8'h02);
      send_byte(8'h40);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (TIMEOUT - 1) @(posedge clk);
      @(negedge clk);
      check("timeout_not_early", {31'd0, err}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("timeout_err", {31'd0, err}, 32'd1);
      check("timeout_done", {31'd0, done}, 32'd0);
      check("timeout_words", 32'(words_loaded), 32'd0);

      // good load, then reload A5 01 11 22 33
      fill_random(3);
      run_frame(3, 1'b0, 2, 1'b0);
      frame_words.delete();
      frame_words.push_back(16'h1122);
      run_frame(1, 1'b0, 0, 1'b1);

      // reset between hi and lo bytes
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(8'h11);
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_outputs", {mem_addr, mem_wdata, core_run, done, err}, 32'd0);
      check("midreset_words", 32'(words_loaded), 32'd0);
      send_byte(8'h22);
      idle(5);
      check("midreset_still_idle", {29'd0, core_run, done, err}, 32'd0);

      // random frames with random gaps and occasional corrupt checksum
      for (int f = 0; f < 6; f++) begin
         int n;
         n = $urandom_range(1, 12);
         fill_random(n);
         run_frame(n, ($urandom_range(0, 3) == 0), 4, 1'b0);
      end

      // N=0: full 256-word image
      fill_random(1 << ADDR_W);
      run_frame(0, 1'b0, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader: the write side of the processor's instruction memory.
- Accepts a framed byte stream (from a UART receiver or host bridge), packs byte pairs into 16-bit instruction words, and writes them sequentially into instruction memory from address 0.
- Validates an XOR checksum.
- Holds the core stopped (core_run low) until a load completes cleanly.

Parameters:
- ADDR_W, 8: instruction memory address width; depth = 2^ADDR_W words.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 1000: max idle cycles between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; transfer = rx_valid & rx_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  instruction word; bit 0 = MSB, matching core bit ordering.
- core_run  output  1  1 = core may fetch/execute; 0 = core held.
- done  output  1  last frame loaded and checksum good.
- err  output  1  last frame failed (bad checksum or timeout).
- words_loaded  output  ADDR_W+1  words written in current/last frame.

Behaviour:
- Reset (synchronous, active-high): state IDLE; rx_ready=0 during the reset cycle, 1 after; mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, done=0, err=0, words_loaded=0. Reset mid-frame discards the frame; no write is issued after reset asserts.
- Frame format: SYNC_BYTE, N, then N word pairs (hi byte, lo byte), then CHK = XOR of all 2N data bytes. N=0 means 2^ADDR_W words.
- FSM states: IDLE, COUNT, HI, LO, WRITE, CHK, DONE, ERR.
- IDLE: accepted byte == SYNC_BYTE -> COUNT and clear done, err, words_loaded, checksum accumulator, and address; core_run=0. Other bytes are accepted and discarded.
- COUNT: latch N into the remaining-word counter -> HI.
- HI: latch hi byte, XOR into accumulator -> LO.
- LO: latch lo byte, XOR into accumulator -> WRITE.
- WRITE, one cycle: mem_we=1, mem_addr=current address, mem_wdata={hi,lo}; rx_ready=0 this cycle only. Then address++ (wraps modulo 2^ADDR_W), words_loaded++, remaining--. Remaining==0 after decrement -> CHK, else -> HI.
- CHK: accepted byte == accumulator -> DONE; otherwise -> ERR.
- DONE: done=1, core_run=1 (registered, asserts the cycle after the CHK byte is accepted).
- ERR: err=1, core_run=0. Words already written are not rolled back.
- DONE/ERR: a SYNC_BYTE starts a new frame exactly as from IDLE (core_run drops the next cycle). Other bytes are ignored.
- Timeout: in COUNT/HI/LO/CHK, an idle counter resets on each accepted byte and increments otherwise; reaching TIMEOUT -> ERR. The counter does not run in IDLE/DONE/ERR/WRITE.
- Minimum latency: last lo byte accepted at cycle t -> mem_we at t+1 -> CHK accepted no earlier than t+2 -> core_run at t+3.
- mem_we is never asserted outside WRITE. done and err are never both 1.

Test Plan:
- Good frame: A5 02 40 05 F8 01 BC, back-to-back rx_valid -> writes addr0=0x4005, addr1=0xF801; two single-cycle mem_we pulses; rx_ready low in each write cycle; words_loaded=2; done=1; core_run=1; err=0.
- Bad checksum: same frame with CHK=BD -> both writes still occur; err=1; done=0; core_run=0.
- Garbage before sync: 00 FF 13 then the good frame -> leading bytes ignored, no mem_we; result identical to the good-frame case.
- Timeout: A5 02 40, then rx_valid low for TIMEOUT cycles -> err=1 exactly TIMEOUT cycles after the 40 byte; no mem_we.
- Reload and reset: after a good load, send A5 01 11 22 33 -> core_run low the cycle after A5, addr0=0x1122, done=1. Separately, assert rst between hi and lo bytes -> all outputs at reset values; the following lo byte produces no write.
- N=0 (ADDR_W=8): 256 words with a correct CHK -> addresses 0..255 written once each; words_loaded=256; done=1.
